seven_seg_scan_driver: RTL and testbench
========================================

Name: seven_seg_scan_driver

Overview:
Multiplexed N-digit hex seven-segment driver. It takes a packed 4-bit-per-digit value and time-multiplexes the digits onto one shared segment bus with per-digit enables. It adds hex A-F decode, decimal points, leading-zero suppression, anti-ghosting dead time and tear-free frame-synchronous update. It sits between the datapath and the board display pins.

Parameters:
DIGITS, 4, number of digits (2..8); digit 0 is least significant.
SCAN_DIV, 1000, clock cycles per digit slot (>= 4).
DEAD_CYCLES, 2, blank cycles at the start of each slot (1..SCAN_DIV-2).
SEG_ACTIVE_LOW, 0, 1 inverts seg and dp at the pins.
DIG_ACTIVE_LOW, 0, 1 inverts digit_sel at the pins.

Ports:
clk  in  1  system clock
rst_n  in  1  reset
value  in  4*DIGITS  nibble k = digit k
dp_in  in  DIGITS  decimal point per digit
load  in  1  capture value/dp_in/lz_en into the pending register
lz_en  in  1  leading-zero suppression enable (captured with load)
enable  in  1  scanning enable
seg  out  7  segments, seg[6]=a ... seg[0]=g
dp  out  1  decimal point segment
digit_sel  out  DIGITS  one-hot digit enable
frame_done  out  1  1-cycle pulse at the end of each frame

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset: pending and display registers = 0 and lz_en = 0. Slot counter cnt = 0, digit index idx = 0, frame_done = 0. seg, dp and digit_sel are at their inactive pin levels (all-off after polarity).
- Scan: cnt counts 0..SCAN_DIV-1 while enable = 1. At wrap, idx increments; idx wraps from DIGITS-1 to 0.
- Frame end: the cycle with idx = DIGITS-1 and cnt = SCAN_DIV-1.
- Outputs are registered with 1-cycle latency from the (cnt, idx) state.
- Dead time: when cnt < DEAD_CYCLES, seg, dp and digit_sel are all inactive.
- Active slot: otherwise, digit_sel is one-hot on bit idx, and seg/dp show the display-register digit idx.
- Decode table (abcdefg):
  0=1111110 1=0110000 2=1101101 3=1111001 4=0110011 5=1011011 6=1011111 7=1110000
  8=1111111 9=1111011 A=1110111 b=0011111 C=1001110 d=0111101 E=1001111 F=1000111
- Leading-zero suppression (display lz_en = 1): digit k > 0 is suppressed when it and all digits above it are 0.
  - Suppressed digit: seg all-off, but digit_sel is still asserted and dp still follows dp_in[k].
  - Digit 0 is never suppressed.
- Load: load = 1 copies value, dp_in and lz_en into pending on the next edge. Multiple loads within a frame: last one wins.
- Frame-synchronous update: pending is copied to display only at frame end, and only if a load occurred since the last transfer.
  - A load in the frame-end cycle itself is included in that transfer.
  - A frame never shows mixed old/new digits.
- frame_done: asserted for 1 cycle, registered, in the cycle after frame end.
- enable = 0: cnt and idx are held at 0, outputs inactive, frame_done = 0. Loads are still accepted.
  - While disabled, pending transfers directly to display on the cycle after load.
  - Re-enable starts at idx 0, cnt 0 (a dead-time slot).
- rst_n deasserted mid-frame: everything returns immediately to reset values; no partial pin pattern may persist.
- Polarity: inversion is applied only at the final output register.

Test Plan:
- Reset and idle. DIGITS=4, SCAN_DIV=8, DEAD_CYCLES=2, enable=0. Assert rst_n=0 mid-scan -> seg=0000000, dp=0, digit_sel=0000 immediately. Release -> outputs stay off.
- Full decode. Load value=16'h7A3F, dp_in=0100, enable=1. Per frame:
  - digit_sel 0001 with seg 1000111 (F).
  - 0010 with seg 1111001 (3).
  - 0100 with seg 1110111 (A) and dp=1.
  - 1000 with seg 1110000 (7).
  - Each digit active for 6 cycles after 2 blank cycles. frame_done pulses every 32 cycles.
- Leading-zero suppression. value=16'h0005, lz_en=1 -> digits 3..1 seg=0000000 but digit_sel still asserted; digit 0 seg=1011011. Repeat with lz_en=0 -> digits 3..1 show 1111110.
- Tear-free update. Load 16'h1111 mid-frame (idx=1) -> the remaining slots of that frame still show the old value. The next frame shows all 0110000. A load on the frame-end cycle takes effect in the very next frame.
- Polarity. SEG_ACTIVE_LOW=1, DIG_ACTIVE_LOW=1, value digit 8:
  - Active slot: seg=0000000, digit_sel has a single 0.
  - Dead time and reset: seg=1111111, dp=1, digit_sel all 1s.
- Enable toggling. Drop enable at idx=2 -> outputs inactive the next cycle. Re-enable -> the first active digit is idx 0 after 2 dead cycles; no frame_done until a complete frame.

Source files
------------

// File: rtl/seven_seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_driver
//   Time-multiplexes DIGITS hex nibbles onto one shared seven-segment bus.
//   Each digit slot lasts SCAN_DIV cycles, and the first DEAD_CYCLES of a slot
//   are blanked so the previous digit does not ghost onto the next one.
//   New values are staged in a pending register. They reach the display
//   register only at frame end, so a frame never shows mixed digits.
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   value       packed digits, nibble k = digit k (digit 0 least significant)
//   dp_in       decimal point per digit
//   load        capture value/dp_in/lz_en into the pending register
//   lz_en       leading-zero suppression enable (captured with load)
//   enable      scanning enable
//   seg         segments a..g on seg[6]..seg[0] (pin polarity applied)
//   dp          decimal point segment (pin polarity applied)
//   digit_sel   one-hot digit enable (pin polarity applied)
//   frame_done  1-cycle pulse in the cycle after the last slot of a frame
// ---------------------------------------------------------------------------
module seven_seg_scan_driver #(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 1000,
  parameter int DEAD_CYCLES    = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  lz_en,
  input  logic                  enable,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  frame_done
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  DEAD_END = CNT_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [6:0]        SEG_INV  = {7{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] DIG_INV  = {DIGITS{DIG_ACTIVE_LOW}};

  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  logic [4*DIGITS-1:0] pendValue, dispValue;
  logic [DIGITS-1:0]   pendDp, dispDp;
  logic                pendLz, dispLz, pendValid;

  logic                frameEnd, showDigit, zeroRun;
  logic [3:0]          curNibble;
  logic                curDp, curBlank;
  logic [DIGITS-1:0]   blankDigit, selOneHot;
  logic [6:0]          nextSeg;
  logic                nextDp;
  logic [DIGITS-1:0]   nextSel;

  function automatic logic [6:0] decodeHex(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

  assign frameEnd  = enable && (idx == IDX_LAST) && (cnt == CNT_LAST);
  assign showDigit = enable && (cnt >= DEAD_END);

  always_comb begin
    zeroRun    = 1'b1;
    blankDigit = '0;
    selOneHot  = '0;
    curNibble  = 4'h0;
    curDp      = 1'b0;
    curBlank   = 1'b0;
    // Walk down from the top digit: a digit is blanked while every digit
    // from it upward is zero. Digit 0 is never blanked.
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zeroRun       = zeroRun && (dispValue[4*k +: 4] == 4'h0);
      blankDigit[k] = dispLz && zeroRun;
    end
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        selOneHot[k] = 1'b1;
        curNibble    = dispValue[4*k +: 4];
        curDp        = dispDp[k];
        curBlank     = blankDigit[k];
      end
    end
    nextSeg = (showDigit && !curBlank) ? decodeHex(curNibble) : 7'b0;
    nextDp  = showDigit && curDp;
    nextSel = showDigit ? selOneHot : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (!enable) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // A load in the frame-end cycle bypasses pending straight into display so
  // it lands in the very next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pendValue <= '0;
      pendDp    <= '0;
      pendLz    <= 1'b0;
      pendValid <= 1'b0;
      dispValue <= '0;
      dispDp    <= '0;
      dispLz    <= 1'b0;
    end else begin
      if (load) begin
        pendValue <= value;
        pendDp    <= dp_in;
        pendLz    <= lz_en;
      end
      if (frameEnd && (load || pendValid)) begin
        dispValue <= load ? value : pendValue;
        dispDp    <= load ? dp_in : pendDp;
        dispLz    <= load ? lz_en : pendLz;
        pendValid <= 1'b0;
      end else if (!enable && pendValid) begin
        dispValue <= pendValue;
        dispDp    <= pendDp;
        dispLz    <= pendLz;
        pendValid <= load;
      end else if (load) begin
        pendValid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= SEG_INV;
      dp         <= SEG_ACTIVE_LOW;
      digit_sel  <= DIG_INV;
      frame_done <= 1'b0;
    end else begin
      seg        <= nextSeg ^ SEG_INV;
      dp         <= nextDp ^ SEG_ACTIVE_LOW;
      digit_sel  <= nextSel ^ DIG_INV;
      frame_done <= frameEnd;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
module tb_seven_seg_scan_driver;

  logic        clk;
  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  dpIn;
  logic        load, lzEn, enable;
  logic [6:0]  seg, segInv;
  logic        dp, dpInv;
  logic [3:0]  digitSel, digitSelInv;
  logic        frameDone, frameDoneInv;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [15:0]     value;
    logic [3:0]      dpIn;
    logic            lz;
    logic [3:0][6:0] segs;   // expected active-high segments, index = digit
  } vecT;

  vecT        vecs [8];
  vecT        vecOnes, vecTwos, vecZeros;
  logic [6:0] expSeg [4];
  logic [3:0] expDp;

  seven_seg_scan_driver #(
    .DIGITS(4), .SCAN_DIV(8), .DEAD_CYCLES(2),
    .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dpIn), .load(load),
    .lz_en(lzEn), .enable(enable), .seg(seg), .dp(dp),
    .digit_sel(digitSel), .frame_done(frameDone)
  );

  seven_seg_scan_driver #(
    .DIGITS(4), .SCAN_DIV(8), .DEAD_CYCLES(2),
    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) dutInv (
    .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dpIn), .load(load),
    .lz_en(lzEn), .enable(enable), .seg(segInv), .dp(dpInv),
    .digit_sel(digitSelInv), .frame_done(frameDoneInv)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic compare(input string name, input int n,
                         input logic [12:0] got, input logic [12:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s cycle %0d: got {seg,dp,sel,fd}=%h, expected %h",
               name, n, got, want);
    end
  endtask

  task automatic checkIdle(input string name);
    compare(name, 0, {seg, dp, digitSel, frameDone}, 13'h0);
    compare({name, "_inv"}, 0, {segInv, dpInv, digitSelInv, frameDoneInv},
            {7'h7F, 1'b1, 4'hF, 1'b0});
  endtask

  task automatic setExpected(input vecT v);
    for (int i = 0; i < 4; i++) expSeg[i] = v.segs[i];
    expDp = v.dpIn;
  endtask

  // n = number of clock edges since enable was raised with cnt=idx=0.
  // The sample after edge n reflects the (cnt,idx) state after edge n-1.
  task automatic checkSample(input string name, input int n);
    int         c, i;
    logic [6:0] s;
    logic       d, fd;
    logic [3:0] sel;
    c = (n - 1) % 8;
    i = ((n - 1) / 8) % 4;
    if (c < 2) begin
      s = 7'h0; d = 1'b0; sel = 4'h0;
    end else begin
      s = expSeg[i]; d = expDp[i]; sel = 4'(1 << i);
    end
    fd = ((n - 1) % 32) == 31;
    compare(name, n, {seg, dp, digitSel, frameDone}, {s, d, sel, fd});
    compare({name, "_inv"}, n, {segInv, dpInv, digitSelInv, frameDoneInv},
            {~s, ~d, ~sel, fd});
  endtask

  task automatic loadWhileDisabled(input vecT v);
    value = v.value; dpIn = v.dpIn; lzEn = v.lz; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
  endtask

  task automatic pulseLoad(input logic [15:0] v);
    value = v; dpIn = 4'h0; lzEn = 1'b0; load = 1'b1;
  endtask

  initial begin
    vecs[0] = '{16'h7A3F, 4'b0100, 1'b0, {7'b1110000, 7'b1110111, 7'b1111001, 7'b1000111}};
    vecs[1] = '{16'h0005, 4'b0000, 1'b1, {7'b0000000, 7'b0000000, 7'b0000000, 7'b1011011}};
    vecs[2] = '{16'h0005, 4'b0000, 1'b0, {7'b1111110, 7'b1111110, 7'b1111110, 7'b1011011}};
    vecs[3] = '{16'h0B0C, 4'b1001, 1'b1, {7'b0000000, 7'b0011111, 7'b1111110, 7'b1001110}};
    vecs[4] = '{16'h0000, 4'b0010, 1'b1, {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110}};
    vecs[5] = '{16'h89E6, 4'b1000, 1'b1, {7'b1111111, 7'b1111011, 7'b1001111, 7'b1011111}};
    vecs[6] = '{16'h42D0, 4'b0001, 1'b0, {7'b0110011, 7'b1101101, 7'b0111101, 7'b1111110}};
    vecs[7] = '{16'h1111, 4'b1111, 1'b1, {4{7'b0110000}}};
    vecOnes  = '{16'h1111, 4'b0000, 1'b0, {4{7'b0110000}}};
    vecTwos  = '{16'h2222, 4'b0000, 1'b0, {4{7'b1101101}}};
    vecZeros = '{16'h0000, 4'b0000, 1'b0, {4{7'b1111110}}};

    rst_n = 1'b1; enable = 1'b0; load = 1'b0;
    value = 16'h0; dpIn = 4'h0; lzEn = 1'b0;
    #2 rst_n = 1'b0;
    #1 checkIdle("reset");
    tick();
    checkIdle("reset_held");
    rst_n = 1'b1;
    repeat (3) tick();
    checkIdle("idle_disabled");

    // Table-driven decode / suppression / dp vectors, one full frame each.
    for (int v = 0; v < 8; v++) begin
      loadWhileDisabled(vecs[v]);
      checkIdle($sformatf("vec%0d_disabled", v));
      setExpected(vecs[v]);
      enable = 1'b1;
      for (int n = 1; n <= 32; n++) begin
        tick();
        checkSample($sformatf("vec%0d", v), n);
      end
      enable = 1'b0;
      tick();
      checkIdle($sformatf("vec%0d_off", v));
    end

    // Tear-free update: mid-frame load, repeated load, frame-end-cycle load.
    loadWhileDisabled(vecs[0]);
    enable = 1'b1;
    for (int n = 1; n <= 96; n++) begin
      tick();
      if (n <= 32)      setExpected(vecs[0]);
      else if (n <= 64) setExpected(vecOnes);
      else              setExpected(vecTwos);
      checkSample("tearfree", n);
      if (n == 10)      pulseLoad(16'h1111);
      else if (n == 40) pulseLoad(16'h3333);
      else if (n == 63) pulseLoad(16'h2222);
      else              load = 1'b0;
    end
    load = 1'b0;
    enable = 1'b0;
    tick();
    checkIdle("tearfree_off");

    // Enable toggling mid-frame at idx 2.
    loadWhileDisabled(vecs[0]);
    setExpected(vecs[0]);
    enable = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      checkSample("pre_toggle", n);
    end
    enable = 1'b0;
    for (int n = 0; n < 4; n++) begin
      tick();
      checkIdle("toggle_off");
    end
    enable = 1'b1;
    for (int n = 1; n <= 32; n++) begin
      tick();
      checkSample("reenable", n);
    end

    // Asynchronous reset in the middle of an active slot.
    enable = 1'b0;
    tick();
    loadWhileDisabled(vecs[0]);
    enable = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      checkSample("pre_reset", n);
    end
    #3 rst_n = 1'b0;
    #1 checkIdle("async_reset");
    enable = 1'b0;
    tick();
    checkIdle("async_reset_held");
    rst_n = 1'b1;
    repeat (2) tick();
    checkIdle("post_reset_idle");
    setExpected(vecZeros);
    enable = 1'b1;
    for (int n = 1; n <= 32; n++) begin
      tick();
      checkSample("post_reset", n);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
